// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A clock divider produces one pixel step every
// CLK_DIV system clocks. On each step the horizontal/vertical counters advance and every
// output is recomputed from the new position, so all outputs change on the same edge.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high, has priority over en
//   en           run enable; low freezes divider, counters and frame counter
//   pix_ce       one-clock pulse per pixel step
//   x, y         current horizontal / vertical position
//   active       high inside the visible area
//   hsync, vsync sync outputs at H_POL / V_POL asserted level
//   line_start   pulse on the step where x becomes 0
//   frame_start  pulse on the step where (x,y) becomes (0,0)
//   frame_cnt    completed-frame index; reads 0 during the first frame after reset
//
// Every output comes straight from a flop, so there is no input-to-output combinational path.
// ---------------------------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               pix_ce,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    // -----------------------------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------------------------
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A divide-by-one still needs a 1-bit counter so the declarations stay legal.
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);

    // Region bounds are compared one bit wider than the coordinates: a sync pulse that ends
    // exactly at H_TOTAL (zero back porch) would otherwise not fit in COORD_W bits.
    localparam int unsigned        CW1      = COORD_W + 1;
    localparam logic [COORD_W:0]   H_ACT_E  = CW1'(H_ACTIVE);
    localparam logic [COORD_W:0]   H_SYN_B  = CW1'(H_ACTIVE + H_FP);
    localparam logic [COORD_W:0]   H_SYN_E  = CW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W:0]   V_ACT_E  = CW1'(V_ACTIVE);
    localparam logic [COORD_W:0]   V_SYN_B  = CW1'(V_ACTIVE + V_FP);
    localparam logic [COORD_W:0]   V_SYN_E  = CW1'(V_ACTIVE + V_FP + V_SYNC);

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic [DIV_W-1:0]   div_q,         div_d;
    logic [COORD_W-1:0] x_q,           x_d;
    logic [COORD_W-1:0] y_q,           y_d;
    logic               active_q,      active_d;
    logic               hsync_q,       hsync_d;
    logic               vsync_q,       vsync_d;
    logic               pix_ce_q,      pix_ce_d;
    logic               line_start_q,  line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_cnt_q,   frame_cnt_d;

    logic step;
    logic x_wrap;
    logic in_h_act;
    logic in_v_act;
    logic in_h_sync;
    logic in_v_sync;

    // -----------------------------------------------------------------------------------------
    // Divider: a pixel step happens on the edge where the divider sits at its last count.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        step  = en && (div_q == DIV_LAST);
        div_d = div_q;
        if (en) begin
            div_d = step ? '0 : div_q + DIV_W'(1);
        end
    end

    // -----------------------------------------------------------------------------------------
    // Raster counters
    // -----------------------------------------------------------------------------------------
    always_comb begin
        x_wrap = (x_q == X_LAST);
        x_d    = x_q;
        y_d    = y_q;
        if (step) begin
            x_d = x_wrap ? '0 : x_q + COORD_W'(1);
            if (x_wrap) begin
                y_d = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Region decode on the next position, so the registered outputs line up with x/y.
    // y only moves on an x wrap, hence vsync can only change there as well.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        in_h_act  = ({1'b0, x_d} < H_ACT_E);
        in_v_act  = ({1'b0, y_d} < V_ACT_E);
        in_h_sync = ({1'b0, x_d} >= H_SYN_B) && ({1'b0, x_d} < H_SYN_E);
        in_v_sync = ({1'b0, y_d} >= V_SYN_B) && ({1'b0, y_d} < V_SYN_E);
    end

    // -----------------------------------------------------------------------------------------
    // Output next-state: levels hold between steps, strobes are single-cycle.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        active_d      = active_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        pix_ce_d      = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        if (step) begin
            active_d      = in_h_act && in_v_act;
            hsync_d       = in_h_sync ? H_POL : ~H_POL;
            vsync_d       = in_v_sync ? V_POL : ~V_POL;
            pix_ce_d      = 1'b1;
            line_start_d  = (x_d == '0);
            frame_start_d = (x_d == '0) && (y_d == '0);
            // Reset leaves the counter at all ones so the first frame reads 0.
            if (frame_start_d) begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Registers. Reset parks the raster on the last blanking pixel so the first step after
    // release lands on (0,0).
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= '0;
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            active_q      <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            pix_ce_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '1;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_ce_q      <= pix_ce_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three generators run side by side: default 640x480 timing at CLK_DIV=4 (index 0), default
// timing at CLK_DIV=1 (index 1) and a tiny 8x6 raster with FRAME_W=2 (index 2). A reference
// model tracks each one as a linear pixel index into the frame and derives x/y/regions from
// it arithmetically; it is compared with the DUTs every cycle, with directed checks on top.
// ---------------------------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_v [3];
    logic en_v  [3];

    logic        op  [3];
    logic [9:0]  ox  [3];
    logic [9:0]  oy  [3];
    logic        oa  [3];
    logic        oh  [3];
    logic        ov  [3];
    logic        ol  [3];
    logic        ofs [3];
    logic [15:0] ofc [3];

    logic [3:0]  sm_x;
    logic [3:0]  sm_y;
    logic [1:0]  sm_fc;

    assign ox[2]  = {6'd0, sm_x};
    assign oy[2]  = {6'd0, sm_y};
    assign ofc[2] = {14'd0, sm_fc};

    vga_timing_gen #(
        .CLK_DIV (4)
    ) u_def (
        .clk         (clk),
        .rst         (rst_v[0]),
        .en          (en_v[0]),
        .pix_ce      (op[0]),
        .x           (ox[0]),
        .y           (oy[0]),
        .active      (oa[0]),
        .hsync       (oh[0]),
        .vsync       (ov[0]),
        .line_start  (ol[0]),
        .frame_start (ofs[0]),
        .frame_cnt   (ofc[0])
    );

    vga_timing_gen #(
        .CLK_DIV (1)
    ) u_d1 (
        .clk         (clk),
        .rst         (rst_v[1]),
        .en          (en_v[1]),
        .pix_ce      (op[1]),
        .x           (ox[1]),
        .y           (oy[1]),
        .active      (oa[1]),
        .hsync       (oh[1]),
        .vsync       (ov[1]),
        .line_start  (ol[1]),
        .frame_start (ofs[1]),
        .frame_cnt   (ofc[1])
    );

    vga_timing_gen #(
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (2),
        .H_BP     (1),
        .V_ACTIVE (3),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .H_POL    (1'b1),
        .V_POL    (1'b0),
        .CLK_DIV  (1),
        .COORD_W  (4),
        .FRAME_W  (2)
    ) u_sm (
        .clk         (clk),
        .rst         (rst_v[2]),
        .en          (en_v[2]),
        .pix_ce      (op[2]),
        .x           (sm_x),
        .y           (sm_y),
        .active      (oa[2]),
        .hsync       (oh[2]),
        .vsync       (ov[2]),
        .line_start  (ol[2]),
        .frame_start (ofs[2]),
        .frame_cnt   (sm_fc)
    );

    // Timing of each instance: active, front porch, sync, back porch (H then V).
    int ha  [3] = '{640, 640, 4};
    int hf  [3] = '{16, 16, 1};
    int hsw [3] = '{96, 96, 2};
    int hb  [3] = '{48, 48, 1};
    int va  [3] = '{480, 480, 3};
    int vf  [3] = '{10, 10, 1};
    int vsw [3] = '{2, 2, 1};
    int vb  [3] = '{33, 33, 1};
    bit hpl [3] = '{1'b0, 1'b0, 1'b1};
    bit vpl [3] = '{1'b0, 1'b0, 1'b0};
    int cdv [3] = '{4, 1, 1};
    int fmk [3] = '{32'hFFFF, 32'hFFFF, 32'h3};

    // Reference model: enabled-cycle phase, pixel index within the frame, frame count.
    int m_div [3];
    int m_pos [3];
    int m_fc  [3];
    bit m_pce [3];
    bit m_ls  [3];
    bit m_fs  [3];
    bit m_act [3];
    bit m_hs  [3];
    bit m_vs  [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int ht;
            int tot;
            int p;
            int xx;
            int yy;
            bit st;
            ht  = ha[i] + hf[i] + hsw[i] + hb[i];
            tot = ht * (va[i] + vf[i] + vsw[i] + vb[i]);
            if (rst_v[i]) begin
                m_div[i] <= 0;
                m_pos[i] <= tot - 1;
                m_fc[i]  <= fmk[i];
                m_pce[i] <= 1'b0;
                m_ls[i]  <= 1'b0;
                m_fs[i]  <= 1'b0;
                m_act[i] <= 1'b0;
                m_hs[i]  <= !hpl[i];
                m_vs[i]  <= !vpl[i];
            end else begin
                st = en_v[i] && (m_div[i] + 1 == cdv[i]);
                if (en_v[i]) m_div[i] <= st ? 0 : m_div[i] + 1;
                m_pce[i] <= st;
                m_ls[i]  <= 1'b0;
                m_fs[i]  <= 1'b0;
                if (st) begin
                    p  = (m_pos[i] + 1) % tot;
                    xx = p % ht;
                    yy = p / ht;
                    m_pos[i] <= p;
                    m_act[i] <= (xx < ha[i]) && (yy < va[i]);
                    m_hs[i]  <= (xx >= ha[i] + hf[i] && xx < ha[i] + hf[i] + hsw[i]) ?
                                hpl[i] : !hpl[i];
                    m_vs[i]  <= (yy >= va[i] + vf[i] && yy < va[i] + vf[i] + vsw[i]) ?
                                vpl[i] : !vpl[i];
                    m_ls[i]  <= (xx == 0);
                    m_fs[i]  <= (p == 0);
                    if (p == 0) m_fc[i] <= (m_fc[i] + 1) & fmk[i];
                end
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] t=%0t: observed %0h expected %0h", tag, i, $time, got, exp);
        end
    endtask

    function automatic int htot(input int i);
        return ha[i] + hf[i] + hsw[i] + hb[i];
    endfunction

    // Advance one clock and compare every output of every instance with the model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("pix_ce", i, 32'(op[i]), 32'(m_pce[i]));
            chk("x", i, 32'(ox[i]), 32'(m_pos[i] % htot(i)));
            chk("y", i, 32'(oy[i]), 32'(m_pos[i] / htot(i)));
            chk("active", i, 32'(oa[i]), 32'(m_act[i]));
            chk("hsync", i, 32'(oh[i]), 32'(m_hs[i]));
            chk("vsync", i, 32'(ov[i]), 32'(m_vs[i]));
            chk("line_start", i, 32'(ol[i]), 32'(m_ls[i]));
            chk("frame_start", i, 32'(ofs[i]), 32'(m_fs[i]));
            chk("frame_cnt", i, 32'(ofc[i]), 32'(m_fc[i]));
        end
    endtask

    initial begin
        int guard;

        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1;
            en_v[i]  = 1'b1;
        end
        repeat (3) tick();

        // Reset state of the default generator.
        chk("rst_x", 0, 32'(ox[0]), 32'd799);
        chk("rst_y", 0, 32'(oy[0]), 32'd524);
        chk("rst_active", 0, 32'(oa[0]), 32'd0);
        chk("rst_hsync", 0, 32'(oh[0]), 32'd1);
        chk("rst_vsync", 0, 32'(ov[0]), 32'd1);
        chk("rst_fcnt", 0, 32'(ofc[0]), 32'hFFFF);
        chk("rst_hsync_sm", 2, 32'(oh[2]), 32'd0);
        chk("rst_fcnt_sm", 2, 32'(ofc[2]), 32'd3);

        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

        // First pixel step lands on the 4th edge after release.
        repeat (3) begin
            tick();
            chk("early_pix_ce", 0, 32'(op[0]), 32'd0);
        end
        tick();
        chk("first_pix_ce", 0, 32'(op[0]), 32'd1);
        chk("first_x", 0, 32'(ox[0]), 32'd0);
        chk("first_y", 0, 32'(oy[0]), 32'd0);
        chk("first_fstart", 0, 32'(ofs[0]), 32'd1);
        chk("first_fcnt", 0, 32'(ofc[0]), 32'd0);
        chk("first_active", 0, 32'(oa[0]), 32'd1);

        // Run to x=100 on the default generator; the small raster runs with random enable.
        guard = 0;
        while (!(m_pce[0] && (m_pos[0] % 800 == 100)) && guard < 2000) begin
            en_v[2] = ($urandom_range(3) != 0);
            tick();
            guard++;
        end
        chk("reach_x100", 0, 32'(guard < 2000), 32'd1);

        // One more clock puts the divider at phase 1, then freeze for 10 clocks.
        tick();
        en_v[0] = 1'b0;
        repeat (10) begin
            en_v[2] = ($urandom_range(3) != 0);
            tick();
            chk("hold_x", 0, 32'(ox[0]), 32'd100);
            chk("hold_pix_ce", 0, 32'(op[0]), 32'd0);
        end
        en_v[0] = 1'b1;
        repeat (2) begin
            tick();
            chk("resume_x", 0, 32'(ox[0]), 32'd100);
        end
        tick();
        chk("resume_step_x", 0, 32'(ox[0]), 32'd101);
        chk("resume_pix_ce", 0, 32'(op[0]), 32'd1);

        // Random enables on the default and small rasters while the CLK_DIV=1 generator
        // crosses line wraps and reaches (300,2).
        guard = 0;
        while (m_pos[1] != 2 * 800 + 300 && guard < 3000) begin
            en_v[0] = ($urandom_range(3) != 0);
            en_v[2] = ($urandom_range(3) != 0);
            tick();
            guard++;
        end
        chk("reach_300_2", 1, 32'(guard < 3000), 32'd1);
        chk("mid_x", 1, 32'(ox[1]), 32'd300);
        chk("mid_y", 1, 32'(oy[1]), 32'd2);

        rst_v[1] = 1'b1;
        tick();
        chk("midrst_x", 1, 32'(ox[1]), 32'd799);
        chk("midrst_y", 1, 32'(oy[1]), 32'd524);
        chk("midrst_fcnt", 1, 32'(ofc[1]), 32'hFFFF);
        chk("midrst_pix_ce", 1, 32'(op[1]), 32'd0);
        rst_v[1] = 1'b0;
        tick();
        chk("restart_x", 1, 32'(ox[1]), 32'd0);
        chk("restart_y", 1, 32'(oy[1]), 32'd0);
        chk("restart_lstart", 1, 32'(ol[1]), 32'd1);
        chk("restart_fstart", 1, 32'(ofs[1]), 32'd1);
        chk("restart_fcnt", 1, 32'(ofc[1]), 32'd0);

        // Small raster, continuous: a frame every 48 clocks, 2-bit frame counter wraps.
        en_v[2]  = 1'b1;
        rst_v[2] = 1'b1;
        tick();
        rst_v[2] = 1'b0;
        tick();
        chk("sm_fstart0", 2, 32'(ofs[2]), 32'd1);
        chk("sm_fcnt0", 2, 32'(ofc[2]), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            repeat (47) begin
                en_v[0] = ($urandom_range(3) != 0);
                tick();
            end
            tick();
            chk("sm_fstart", 2, 32'(ofs[2]), 32'd1);
            chk("sm_fcnt", 2, 32'(ofc[2]), 32'(k % 4));
            chk("sm_x0", 2, 32'(ox[2]), 32'd0);
            chk("sm_y0", 2, 32'(oy[2]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
